mem_arbiter: RTL

- Shares the single-ported RAM between the instruction-fetch port and the data port of the pipelined CPU.
- The data-side strobes come from the control unit's cuDRE/cuDWE/datomic outputs. The instruction side comes from cuIRE and the PC.
- A registered grant FSM with last-served fairness decides which requester drives the RAM, and returns per-port wait and load signals.
- Optional LL/SC link register supports atomic load-linked / store-conditional.

---
 rtl/cpu_types_pkg.sv | 28 ++
 rtl/arbiter_if.sv | 34 +++
 rtl/mem_arbiter_llsc.sv | 50 +++++
 rtl/mem_arbiter.sv | 149 ++++++++++++++
 4 files changed

// File: rtl/cpu_types_pkg.sv
// Shared CPU types: data word, RAM handshake state and the memory
// arbiter grant state, plus a word-alignment helper for RAM addresses.
package cpu_types_pkg;

  typedef logic [31:0] word_t;

  typedef enum logic [1:0] {
    FREE   = 2'd0,
    BUSY   = 2'd1,
    ACCESS = 2'd2,
    ERROR  = 2'd3
  } ramstate_t;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    DGRANT = 2'd1,
    IGRANT = 2'd2
  } arb_state_t;

  // Clear the n low address bits so the RAM only ever sees aligned words.
  function automatic word_t align_addr(input word_t a, input int unsigned n);
    word_t m;
    m = '1;
    m = m << n;
    return a & m;
  endfunction

endpackage

// File: rtl/arbiter_if.sv
// Signal bundle for the memory arbiter: CPU instruction/data ports and
// the single RAM port. arb is the arbiter's view, tb the environment's.
interface arbiter_if;
  import cpu_types_pkg::*;

  logic  iREN;
  word_t iaddr;
  logic  iwait;
  word_t iload;
  logic  dREN;
  logic  dWEN;
  logic  datomic;
  word_t daddr;
  word_t dstore;
  logic  dwait;
  word_t dload;
  logic  ramREN;
  logic  ramWEN;
  word_t ramaddr;
  word_t ramstore;
  word_t ramload;
  logic [1:0] ramstate;

  modport arb (
    input  iREN, iaddr, dREN, dWEN, datomic, daddr, dstore, ramload, ramstate,
    output iwait, iload, dwait, dload, ramREN, ramWEN, ramaddr, ramstore
  );

  modport tb (
    output iREN, iaddr, dREN, dWEN, datomic, daddr, dstore, ramload, ramstate,
    input  iwait, iload, dwait, dload, ramREN, ramWEN, ramaddr, ramstore
  );

endinterface

// File: rtl/mem_arbiter_llsc.sv
// LL/SC link register for the memory arbiter (only used when LLSC_EN is
// defined). Tracks the address of the last load-linked and judges
// whether a store-conditional may proceed.
module llsc_link
  import cpu_types_pkg::*;
(
  input  logic  clk,
  input  logic  rst_n,
  input  logic  i_ren,
  input  logic  i_wen,
  input  logic  i_atomic,
  input  word_t i_addr,
  input  logic  i_done,
  output logic  o_sc_pass,
  output logic  o_sc_fail
);

  logic  r_link_valid;
  word_t r_link_addr;
  logic  w_is_ll;
  logic  w_is_sc;
  logic  w_match;

  // Write wins over read, so an atomic with both enables is an SC.
  always_comb begin
    w_is_sc   = i_wen & i_atomic;
    w_is_ll   = i_ren & ~i_wen & i_atomic;
    w_match   = r_link_valid && (r_link_addr == i_addr);
    o_sc_pass = w_is_sc & w_match;
    o_sc_fail = w_is_sc & ~w_match;
  end

  // Link update on every completed data access.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_link_valid <= 1'b0;
      r_link_addr  <= '0;
    end else if (i_done) begin
      if (w_is_ll) begin
        r_link_valid <= 1'b1;
        r_link_addr  <= i_addr;
      end else if (w_is_sc) begin
        if (w_match) r_link_valid <= 1'b0;
      end else if (i_wen && (i_addr == r_link_addr)) begin
        r_link_valid <= 1'b0;
      end
    end
  end

endmodule

// File: rtl/mem_arbiter.sv
// Memory arbiter: shares one RAM port between instruction fetch and data
// access with a registered grant FSM and last-served fairness.
// Optional LL/SC support is built when the LLSC_EN macro is defined.
module mem_arbiter
  import cpu_types_pkg::*;
#(
  parameter int unsigned ADDR_ALIGN = 2
) (
  input  logic        CLK,
  input  logic        nRST,
  input  logic        iREN,
  input  logic [31:0] iaddr,
  output logic        iwait,
  output logic [31:0] iload,
  input  logic        dREN,
  input  logic        dWEN,
  input  logic        datomic,
  input  logic [31:0] daddr,
  input  logic [31:0] dstore,
  output logic        dwait,
  output logic [31:0] dload,
  output logic        ramREN,
  output logic        ramWEN,
  output logic [31:0] ramaddr,
  output logic [31:0] ramstore,
  input  logic [31:0] ramload,
  input  logic [1:0]  ramstate
);

  arb_state_t r_state;
  arb_state_t w_state_nxt;
  logic       r_last_d;
  logic       w_last_d_nxt;
  logic       w_dreq;
  logic       w_access;
  logic       w_ddone;
  logic       w_idone;
  logic       w_sc_pass;
  logic       w_sc_fail;

  assign w_dreq   = dREN | dWEN;
  assign w_access = (ramstate == ACCESS);

`ifdef LLSC_EN
  llsc_link u_llsc_link (
    .clk       (CLK),
    .rst_n     (nRST),
    .i_ren     (dREN),
    .i_wen     (dWEN),
    .i_atomic  (datomic),
    .i_addr    (daddr),
    .i_done    (w_ddone),
    .o_sc_pass (w_sc_pass),
    .o_sc_fail (w_sc_fail)
  );
`else
  logic w_unused_atomic;
  assign w_unused_atomic = datomic;
  assign w_sc_pass       = 1'b0;
  assign w_sc_fail       = 1'b0;
`endif

  // Grant state and last-served record.
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      r_state  <= IDLE;
      r_last_d <= 1'b0;
    end else begin
      r_state  <= w_state_nxt;
      r_last_d <= w_last_d_nxt;
    end
  end

  // Next grant: alternate on contention, release after every completion.
  always_comb begin
    w_state_nxt  = r_state;
    w_last_d_nxt = r_last_d;
    unique case (r_state)
      IDLE: begin
        if (w_dreq && iREN) w_state_nxt = r_last_d ? IGRANT : DGRANT;
        else if (w_dreq)    w_state_nxt = DGRANT;
        else if (iREN)      w_state_nxt = IGRANT;
      end
      DGRANT: begin
        if (!w_dreq) begin
          w_state_nxt = IDLE;
        end else if (w_ddone) begin
          w_state_nxt  = IDLE;
          w_last_d_nxt = 1'b1;
        end
      end
      IGRANT: begin
        if (!iREN) begin
          w_state_nxt = IDLE;
        end else if (w_idone) begin
          w_state_nxt  = IDLE;
          w_last_d_nxt = 1'b0;
        end
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  // RAM drive, waits and load data for the granted port.
  // A failed SC completes at once without touching the RAM, regardless of ramstate.
  always_comb begin
    ramREN   = 1'b0;
    ramWEN   = 1'b0;
    ramaddr  = '0;
    ramstore = '0;
    iload    = '0;
    dload    = '0;
    iwait    = iREN;
    dwait    = w_dreq;
    w_ddone  = 1'b0;
    w_idone  = 1'b0;
    unique case (r_state)
      DGRANT: begin
        if (w_dreq) begin
          ramaddr  = align_addr(daddr, ADDR_ALIGN);
          ramstore = dstore;
          ramREN   = dREN & ~dWEN;
          ramWEN   = dWEN & ~w_sc_fail;
          if (w_sc_fail) begin
            w_ddone = 1'b1;
            dwait   = 1'b0;
          end else if (w_access) begin
            w_ddone = 1'b1;
            dwait   = 1'b0;
            dload   = w_sc_pass ? 32'd1 : ramload;
          end
        end
      end
      IGRANT: begin
        if (iREN) begin
          ramaddr = align_addr(iaddr, ADDR_ALIGN);
          ramREN  = 1'b1;
          if (w_access) begin
            w_idone = 1'b1;
            iwait   = 1'b0;
            iload   = ramload;
          end
        end
      end
      default: ;
    endcase
  end

endmodule
